// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields and an immediate into a 32-bit word
// behind a single-entry valid/ready output register with address tagging and error counting.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        pc_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic [15:0] err_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [XLEN-1:0]  NOP_WORD = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_STEP  = 32'd4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_U = 7'b0110111;
    localparam logic [6:0] OP_J = 7'b1101111;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } imm_type_e;

    logic                  out_valid_q, out_valid_d;
    logic [XLEN-1:0]       out_word_q,  out_word_d;
    logic [XLEN-1:0]       out_pc_q,    out_pc_d;
    logic                  out_err_q,   out_err_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;
    logic [XLEN-1:0]       pc_next_q,   pc_next_d;

    logic                  accept_c;
    logic [XLEN-1:0]       word_c;
    logic                  err_c;
    logic [XLEN-1:0]       pc_base_c;
    logic signed [XLEN-1:0] imm_s;
    logic                  fits12_c, fits_b_c, fits_j_c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;
    assign imm_s    = $signed(in_imm);

    // Immediate range checks shared by the type encoders
    assign fits12_c = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign fits_b_c = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
    assign fits_j_c = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];

    always_comb begin
        word_c = NOP_WORD;
        err_c  = 1'b0;
        case (imm_type_e'(in_type))
            TYPE_R: word_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            TYPE_I: begin
                word_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
                err_c  = !fits12_c;
            end
            TYPE_S: begin
                word_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
                err_c  = !fits12_c;
            end
            TYPE_B: begin
                word_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], OP_B};
                err_c  = !fits_b_c;
            end
            TYPE_U: begin
                word_c = {in_imm[31:12], in_rd, OP_U};
                err_c  = (in_imm[11:0] != 12'd0);
            end
            TYPE_J: begin
                word_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
                err_c  = !fits_j_c;
            end
            default: err_c = 1'b1;
        endcase
        if (err_c) begin
            word_c = NOP_WORD;
        end
    end

    // pc_clr redirects the address of a same-cycle accept to BASE_ADDR
    assign pc_base_c = pc_clr ? BASE_ADDR : pc_next_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_pc_d    = out_pc_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        pc_next_d   = pc_next_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_word_d  = word_c;
            out_pc_d    = pc_base_c;
            out_err_d   = err_c;
            pc_next_d   = pc_base_c + PC_STEP;
            if (err_c && (err_count_q != CNT_MAX)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (pc_clr) begin
                pc_next_d = BASE_ADDR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_pc_q    <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
            pc_next_q   <= BASE_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_pc_q    <= out_pc_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            pc_next_q   <= pc_next_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_pc    = out_pc_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, errors, backpressure, pc_clr, wrap and async reset.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        pc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word, out_pc;
    logic        out_err;
    logic [15:0] err_count;

    logic        w_in_ready, w_out_valid, w_out_err;
    logic [31:0] w_out_word, w_out_pc;
    logic [15:0] w_err_count;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    logic [31:0] exp_pc;

    instr_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .pc_clr(pc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_pc(out_pc), .out_err(out_err), .err_count(err_count)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .pc_clr(pc_clr),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_word(w_out_word),
        .out_pc(w_out_pc), .out_err(w_out_err), .err_count(w_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_word !== 32'h0) $display("FAIL reset_word got %h exp 0", out_word); else pass_cnt++;
        chk_cnt++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", out_pc); else pass_cnt++;
        chk_cnt++; if (out_err !== 1'b0) $display("FAIL reset_err got %0b exp 0", out_err); else pass_cnt++;
        chk_cnt++; if (err_count !== 16'h0) $display("FAIL reset_errcnt got %0d exp 0", err_count); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_single_i();
        out_ready = 1'b1;
        send(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_pre_valid got %0b exp 0", out_valid); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_word !== 32'hFFF1_0093) $display("FAIL single_word got %h exp FFF10093", out_word); else pass_cnt++;
        chk_cnt++; if (out_err !== 1'b0) $display("FAIL single_err got %0b exp 0", out_err); else pass_cnt++;
        chk_cnt++; if (out_pc !== 32'h0) $display("FAIL single_pc got %h exp 0", out_pc); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drop got %0b exp 0", out_valid); else pass_cnt++;
        exp_pc = 32'h4;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  t   [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
        logic [4:0]  rd  [4] = '{5'd0, 5'd0, 5'd5, 5'd1};
        logic [4:0]  rs1 [4] = '{5'd2, 5'd0, 5'd0, 5'd0};
        logic [4:0]  rs2 [4] = '{5'd5, 5'd0, 5'd0, 5'd0};
        logic [2:0]  f3  [4] = '{3'd2, 3'd0, 3'd0, 3'd0};
        logic [31:0] imm [4] = '{32'd8, 32'hFFFF_FFFC, 32'h1234_5000, 32'd2048};
        logic [31:0] exp [4] = '{32'h0051_2423, 32'hFE00_0EE3, 32'h1234_52B7, 32'h0010_00EF};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(t[i], rd[i], rs1[i], rs2[i], f3[i], 7'd0, imm[i]);
            tick();
            chk_cnt++; if (out_word !== exp[i] || out_valid !== 1'b1 || out_err !== 1'b0)
                $display("FAIL b2b_word%0d got %h v%0b e%0b exp %h v1 e0", i, out_word, out_valid, out_err, exp[i]);
            else pass_cnt++;
            chk_cnt++; if (out_pc !== exp_pc) $display("FAIL b2b_pc%0d got %h exp %h", i, out_pc, exp_pc); else pass_cnt++;
            exp_pc = exp_pc + 32'd4;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        logic [2:0]  t   [5] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd7};
        logic [31:0] imm [5] = '{32'd2048, 32'd3, 32'd1048576, 32'h0000_0001, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(t[i], 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, imm[i]);
            tick();
            chk_cnt++; if (out_word !== 32'h0000_0013 || out_err !== 1'b1)
                $display("FAIL err_word%0d got %h e%0b exp 00000013 e1", i, out_word, out_err);
            else pass_cnt++;
            chk_cnt++; if (err_count !== 16'(i + 1)) $display("FAIL err_count%0d got %0d exp %0d", i, err_count, i + 1); else pass_cnt++;
            chk_cnt++; if (out_pc !== exp_pc) $display("FAIL err_pc%0d got %h exp %h", i, out_pc, exp_pc); else pass_cnt++;
            exp_pc = exp_pc + 32'd4;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        chk_cnt++; if (out_word !== 32'h0050_0193 || out_valid !== 1'b1)
            $display("FAIL bp_first got %h v%0b exp 00500193 v1", out_word, out_valid);
        else pass_cnt++;
        send(3'd1, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %0b exp 0", i, in_ready); else pass_cnt++;
            tick();
            chk_cnt++; if (out_word !== 32'h0050_0193 || out_pc !== exp_pc || out_valid !== 1'b1)
                $display("FAIL bp_hold%0d got %h pc %h exp 00500193 pc %h", i, out_word, out_pc, exp_pc);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b exp 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        exp_pc = exp_pc + 32'd4;
        chk_cnt++; if (out_word !== 32'h0060_0213 || out_pc !== exp_pc || out_valid !== 1'b1)
            $display("FAIL bp_next got %h pc %h exp 00600213 pc %h", out_word, out_pc, exp_pc);
        else pass_cnt++;
        exp_pc = exp_pc + 32'd4;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %0b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_pc_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        pc_clr = 1'b1;
        tick();
        pc_clr = 1'b0;
        send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd32, 32'd0);
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (out_pc !== 32'h0) $display("FAIL clr_alone_pc got %h exp 0", out_pc); else pass_cnt++;
        chk_cnt++; if (out_word !== 32'h4031_00B3) $display("FAIL clr_r_word got %h exp 403100B3", out_word); else pass_cnt++;
        send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        tick();
        send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        pc_clr = 1'b1;
        tick();
        pc_clr = 1'b0;
        chk_cnt++; if (out_pc !== 32'h0) $display("FAIL clr_accept_pc got %h exp 0", out_pc); else pass_cnt++;
        chk_cnt++; if (w_out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_first_pc got %h exp FFFFFFFC", w_out_pc); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (out_pc !== 32'h4) $display("FAIL clr_follow_pc got %h exp 4", out_pc); else pass_cnt++;
        chk_cnt++; if (w_out_pc !== 32'h0) $display("FAIL wrap_second_pc got %h exp 0", w_out_pc); else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7);
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1 || err_count !== 16'd5 || out_pc !== 32'h8)
            $display("FAIL arst_pre got v%0b cnt %0d pc %h exp v1 cnt 5 pc 8", out_valid, err_count, out_pc);
        else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %0b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (err_count !== 16'h0) $display("FAIL arst_errcnt got %0d exp 0", err_count); else pass_cnt++;
        chk_cnt++; if (out_pc !== 32'h0) $display("FAIL arst_pc got %h exp 0", out_pc); else pass_cnt++;
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7);
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (out_pc !== 32'h0 || out_word !== 32'h0071_0093)
            $display("FAIL arst_after got pc %h word %h exp pc 0 word 00710093", out_pc, out_word);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pc_clr = 1'b0;
        in_type = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        exp_pc = 32'h0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single_i();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_pc_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
